// File: rtl/popcount_pkg.sv
// Shared constants and helpers for the popcount stream block.
// Nibble-count width, clog2 and result-width derivation.
package popcount_pkg;

  localparam int NIB_W = 3;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Bits needed to hold a count of 0..width set bits.
  function automatic int cw_of(input int width);
    return clog2(width + 1);
  endfunction

  function automatic logic [NIB_W-1:0] nib_pop(input logic [3:0] v);
    return NIB_W'(v[0]) + NIB_W'(v[1]) + NIB_W'(v[2]) + NIB_W'(v[3]);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational sum of per-nibble counts.
// Exact result, CW bits wide.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0][NIB_W-1:0] nib_i,
  output logic [cw_of(4*N)-1:0]   sum_o
);

  localparam int CW = cw_of(4 * N);

  // Add all nibble counts together.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o = sum_o + CW'(nib_i[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming popcount with saturating packet accumulation.
// Stage 1 counts nibbles, stage 2 sums and accumulates.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int N  = WIDTH / 4;
  localparam int CW = cw_of(WIDTH);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 256 || ACC_W < CW) begin : g_bad_cfg
    $error("popcount_stream: illegal WIDTH/ACC_W");
  end

  logic                   adv;
  logic [N-1:0][NIB_W-1:0] nib;
  logic [CW-1:0]           sum;
  logic [ACC_W:0]          sum_ext;
  logic                    sat;
  logic [ACC_W-1:0]        acc_sat;

  logic                    s1_valid_q, s1_valid_d;
  logic [N-1:0][NIB_W-1:0] s1_nib_q, s1_nib_d;
  logic                    s1_acc_q, s1_acc_d;
  logic                    s1_last_q, s1_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_count_q, out_count_d;
  logic                    out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Per-nibble counts of the incoming word.
  always_comb begin
    nib = '0;
    for (int i = 0; i < N; i++) begin
      nib[i] = nib_pop(in_data[4*i +: 4]);
    end
  end

  popcount_tree #(.N(N)) u_tree (
    .nib_i(s1_nib_q),
    .sum_o(sum)
  );

  // Saturating add of this beat into the running packet sum.
  always_comb begin
    sum_ext = {1'b0, acc_q} + (ACC_W+1)'(sum);
    sat     = sum_ext[ACC_W];
    acc_sat = sat ? '1 : sum_ext[ACC_W-1:0];
  end

  // Stage 1 load: everything holds while the output is stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_nib_d   = s1_nib_q;
    s1_acc_d   = s1_acc_q;
    s1_last_d  = s1_last_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_nib_d   = nib;
      s1_acc_d   = in_acc;
      s1_last_d  = in_last;
    end
  end

  // Stage 2: emit single counts, accumulate or close a packet.
  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        unique case (1'b1)
          (s1_acc_q && s1_last_q): begin
            out_valid_d = 1'b1;
            out_count_d = acc_sat;
            out_ovf_d   = ovf_q || sat;
            acc_d       = '0;
            ovf_d       = 1'b0;
          end
          (s1_acc_q && !s1_last_q): begin
            acc_d = acc_sat;
            ovf_d = ovf_q || sat;
          end
          default: begin
            out_valid_d = 1'b1;
            out_count_d = ACC_W'(sum);
            out_ovf_d   = 1'b0;
          end
        endcase
      end
    end
  end

  // Pipeline and accumulator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_nib_q    <= '0;
      s1_acc_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_nib_q    <= s1_nib_d;
      s1_acc_q    <= s1_acc_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: ACC_W=16 and ACC_W=5 instances
// share stimulus; results are checked through per-instance queues.
module tb_popcount_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_acc = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;

  logic        rdy_a, rdy_b, va, vb, oa, ob;
  logic [15:0] ca;
  logic [4:0]  cb;

  always #5 clk = ~clk;

  popcount_stream #(.WIDTH(16), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .in_acc(in_acc), .in_last(in_last),
    .out_valid(va), .out_ready(out_ready), .out_count(ca), .out_ovf(oa)
  );

  popcount_stream #(.WIDTH(16), .ACC_W(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .in_acc(in_acc), .in_last(in_last),
    .out_valid(vb), .out_ready(out_ready), .out_count(cb), .out_ovf(ob)
  );

  typedef struct {
    int cnt;
    bit ovf;
    int stamp;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    bit a;
    bit l;
    bit e;
    int ca;
    bit oa;
    int cb;
    bit ob;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   lat_chk = 0;
  int   ma = 0, mb = 0;
  bit   fa = 0, fb = 0;
  vec_t tbl [0:20];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void step(input int accw, input int pc, input bit a,
                               input bit l, inout int acc, inout bit f,
                               output bit e, output int cnt, output bit o);
    int mx;
    int s;
    mx  = (1 << accw) - 1;
    e   = 0;
    cnt = 0;
    o   = 0;
    if (!a) begin
      e   = 1;
      cnt = pc;
    end else begin
      s = acc + pc;
      if (s > mx) begin
        s = mx;
        f = 1;
      end
      if (l) begin
        e   = 1;
        cnt = s;
        o   = f;
        acc = 0;
        f   = 0;
      end else begin
        acc = s;
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (va && out_ready) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_result", int'(ca), -1);
        end else begin
          e = qa.pop_front();
          chk("a_count", int'(ca), e.cnt);
          chk("a_ovf", int'(oa), int'(e.ovf));
          if (lat_chk) chk("a_latency", cyc - e.stamp, 2);
        end
      end
      if (vb && out_ready) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_result", int'(cb), -1);
        end else begin
          e = qb.pop_front();
          chk("b_count", int'(cb), e.cnt);
          chk("b_ovf", int'(ob), int'(e.ovf));
          if (lat_chk) chk("b_latency", cyc - e.stamp, 2);
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int k;
    in_valid = 1'b1;
    in_data  = v.d;
    in_acc   = v.a;
    in_last  = v.l;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rdy_a) break;
    end
    if (k == 100) begin
      chk("accept_timeout", 0, 1);
    end else if (v.e) begin
      qa.push_back('{v.ca, v.oa, cyc});
      qb.push_back('{v.cb, v.ob, cyc});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    chk("a_drain_left", qa.size(), 0);
    chk("b_drain_left", qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int c0;
    bit e, o;
    int cnt;
    // d, acc, last, emits, cnt_a, ovf_a, cnt_b, ovf_b
    tbl[0]  = '{16'h0000, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{16'hFFFF, 0, 0, 1, 16, 0, 16, 0};
    tbl[2]  = '{16'hAAAA, 0, 0, 1, 8, 0, 8, 0};
    tbl[3]  = '{16'h5555, 0, 0, 1, 8, 0, 8, 0};
    tbl[4]  = '{16'h00FF, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{16'h000F, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{16'h0001, 1, 1, 1, 13, 0, 13, 0};
    tbl[7]  = '{16'h0003, 1, 1, 1, 2, 0, 2, 0};
    tbl[8]  = '{16'h0007, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{16'h0001, 0, 1, 1, 1, 0, 1, 0};
    tbl[10] = '{16'h0001, 1, 1, 1, 4, 0, 4, 0};
    tbl[11] = '{16'hFFFF, 1, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{16'hFFFF, 1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{16'hFFFF, 1, 1, 1, 48, 0, 31, 1};
    tbl[14] = '{16'h0003, 0, 0, 1, 2, 0, 2, 0};
    tbl[15] = '{16'h000F, 0, 0, 1, 4, 0, 4, 0};
    tbl[16] = '{16'h00FF, 0, 0, 1, 8, 0, 8, 0};
    tbl[17] = '{16'h0FFF, 0, 0, 1, 12, 0, 12, 0};
    tbl[18] = '{16'hFFFF, 0, 0, 1, 16, 0, 16, 0};
    tbl[19] = '{16'h00FF, 1, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{16'h0001, 1, 1, 1, 1, 0, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(va), 0);
    chk("rst_out_count", int'(ca), 0);
    chk("rst_out_ovf", int'(oa), 0);
    chk("rst_in_ready", int'(rdy_a), 1);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(rdy_a), 1);
    @(posedge clk);
    #1;

    // Back-to-back single beats with latency check
    lat_chk = 1;
    for (int i = 0; i < 4; i++) send(tbl[i]);
    drain();
    lat_chk = 0;

    // Packets, interleaved single beat, saturation on the narrow instance
    for (int i = 4; i < 15; i++) send(tbl[i]);
    drain();

    // Output stall for 5 cycles while 4 beats stream in
    out_ready = 1'b0;
    fork
      begin
        for (int i = 15; i < 19; i++) send(tbl[i]);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        c0 = int'(ca);
        chk("stall_first_count", c0, 4);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", int'(rdy_a), 0);
          chk("stall_count_hold", int'(ca), c0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset inside an open packet with a result in flight
    send(tbl[19]);
    send(tbl[19]);
    send(tbl[14]);
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", int'(va), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(va), 0);
    chk("mid_rst_out_count", int'(ca), 0);
    chk("mid_rst_in_ready", int'(rdy_a), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("after_rst_in_ready", int'(rdy_a), 1);
    send(tbl[20]);
    drain();

    // Random traffic against the reference model
    got = 0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_acc    = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && rdy_a) begin
        got++;
        step(16, $countones(in_data), in_acc, in_last, ma, fa, e, cnt, o);
        if (e) qa.push_back('{cnt, o, cyc});
      end
      if (in_valid && rdy_b) begin
        step(5, $countones(in_data), in_acc, in_last, mb, fb, e, cnt, o);
        if (e) qb.push_back('{cnt, o, cyc});
      end
      @(posedge clk);
      #1;
    end
    chk("rand_beats", got, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/popcount_stream.md
POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input word width; multiple of 4, range 4..256.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator/output width; ACC_W >= CW, where CW = clog2(WIDTH+1).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: input beat present.
REQ-006 SHALL have port in_ready, output, 1: block accepts the beat this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: word whose set bits are counted.
REQ-008 SHALL have port in_acc, input, 1: beat belongs to an accumulating packet.
REQ-009 SHALL have port in_last, input, 1: final beat of an accumulating packet; ignored when in_acc=0.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_count, output, ACC_W: popcount result, zero-extended.
REQ-013 SHALL have port out_ovf, output, 1: accumulation saturated for this result.

Function
REQ-014 SHALL accept a beat when in_valid and in_ready are both 1; out_valid/out_ready likewise.
REQ-015 SHALL form a two-stage pipeline advancing only when adv = !out_valid | out_ready; in_ready SHALL equal adv, with no combinational path from in_valid to in_ready.
REQ-016 Stage 1 SHALL register per-nibble counts (WIDTH/4 values, 3 bits each) plus valid, acc and last flags.
REQ-017 Stage 2 SHALL sum the nibble counts (exact, CW bits) and register the result into out_count/out_valid.
REQ-018 A beat with in_acc=0 SHALL produce one result, out_count = popcount(in_data) and out_ovf=0, with out_valid rising exactly 2 cycles after acceptance when out_ready is held 1.
REQ-019 Beats with in_acc=1 and in_last=0 SHALL add their count into the accumulator and produce no result.
REQ-020 A beat with in_acc=1 and in_last=1 SHALL produce one result equal to accumulator + its count, 2 cycles after acceptance; the accumulator SHALL clear to 0 in the same cycle.
REQ-021 Accumulation SHALL saturate at 2^ACC_W-1; a sticky overflow flag SHALL be set on saturation and reported as out_ovf on the packet's result, then cleared with the accumulator.
REQ-022 An in_acc=0 beat arriving inside an open packet SHALL emit its own count and leave the accumulator and overflow flag unchanged.
REQ-023 While out_valid=1 and out_ready=0, out_count, out_ovf, stage-1 contents and the accumulator SHALL hold unchanged, and in_ready SHALL be 0.
REQ-024 With out_ready held 1, the block SHALL sustain one accepted beat per cycle.
REQ-025 in_data=0 SHALL yield count 0; all-ones SHALL yield WIDTH.

Reset
REQ-026 rst=1 SHALL asynchronously clear out_valid, out_count, out_ovf, both stage valid flags, the accumulator and the overflow flag to 0.
REQ-027 Reset mid-packet or mid-pipeline SHALL discard all in-flight beats and partial sums; the first beat after reset SHALL start a new packet.
REQ-028 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-029 A shared package popcount_pkg SHALL hold the clog2 function, the nibble-count width constant (3) and the CW derivation.
REQ-030 The nibble-count summing tree SHALL be a combinational sub-module popcount_tree (parameter N = WIDTH/4), instantiated in stage 2.
REQ-031 Elaboration SHALL fail if WIDTH is not a multiple of 4 or ACC_W < CW.

Verification
REQ-032 WIDTH=16: beats 16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555 with in_acc=0, out_ready=1 -> results 0, 16, 8, 8 in order, each 2 cycles after acceptance, out_ovf=0.
REQ-033 Accumulating packet 16'h00FF, 16'h000F, 16'h0001 (last) -> one result 13; no result for the first two beats; the next packet starts from 0.
REQ-034 ACC_W=5, WIDTH=16: packet of three 16'hFFFF beats -> out_count=31, out_ovf=1; the following in_acc=0 beat 16'h0003 -> 2, out_ovf=0.
REQ-035 out_ready=0 for 5 cycles with a stream of 4 beats -> in_ready=0 once the pipeline fills, out_count stable; after release all 4 results arrive in order with none lost or duplicated.
REQ-036 rst pulsed after two beats of an open packet (16'h00FF, 16'h00FF) -> out_valid=0 at once; new packet 16'h0001 (last) -> result 1.
REQ-037 1000 random beats, random in_acc/in_last/out_ready -> every result matches a reference-model popcount/accumulation.
